// File: rtl/axis_frame_source.sv
`default_nettype none
// ============================================================================
//  Module   : axis_frame_source
//  Purpose  : AXI-Stream master that streams one frame of preloaded words
//             from a small internal buffer, ending the frame with tlast.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_frame_source #(
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int C_FRAME_DEPTH          = 16,
    parameter int C_ADDR_WIDTH           = 4
) (
    input  logic                                  m00_axis_aclk,
    input  logic                                  m00_axis_areset,
    input  logic                                  wr_en,
    input  logic [C_ADDR_WIDTH-1:0]               wr_addr,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]     wr_data,
    input  logic [C_ADDR_WIDTH:0]                 frame_len,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic [15:0]                           frame_count,
    output logic                                  m00_axis_tvalid,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    input  logic                                  m00_axis_tready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [C_ADDR_WIDTH:0] c_depth = (C_ADDR_WIDTH+1)'(C_FRAME_DEPTH);

    state_t                              r_state;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   r_buf [C_FRAME_DEPTH];
    logic [C_ADDR_WIDTH-1:0]             r_idx;
    logic [C_ADDR_WIDTH-1:0]             r_last_idx;
    logic                                r_tvalid;
    logic                                r_tlast;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   r_tdata;
    logic                                r_busy;
    logic                                r_done;
    logic [15:0]                         r_frame_count;

    logic                                w_buf_we;
    logic [C_ADDR_WIDTH:0]               w_len_clamped;
    logic [C_ADDR_WIDTH-1:0]             w_last_idx;
    logic [C_ADDR_WIDTH-1:0]             w_next_idx;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]   w_first_word;

    // Writes only land while idle so an in-flight frame cannot be corrupted.
    assign w_buf_we      = wr_en && (r_state == ST_IDLE);
    assign w_len_clamped = (frame_len > c_depth) ? c_depth : frame_len;
    assign w_last_idx    = C_ADDR_WIDTH'(w_len_clamped - 1);
    assign w_next_idx    = r_idx + C_ADDR_WIDTH'(1);
    // A write to word 0 in the start cycle must be visible in the first beat.
    assign w_first_word  = (w_buf_we && (wr_addr == '0)) ? wr_data : r_buf[0];

    // Frame buffer: plain storage, deliberately not reset so contents survive.
    always_ff @(posedge m00_axis_aclk) begin
        if (w_buf_we) begin
            r_buf[wr_addr] <= wr_data;
        end
    end

    // Frame sequencer with registered AXIS outputs and status.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_last_idx    <= '0;
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frame_count <= 16'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (frame_len == '0) begin
                            r_state       <= ST_FIN;
                            r_done        <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                        end else begin
                            r_state    <= ST_SEND;
                            r_idx      <= '0;
                            r_last_idx <= w_last_idx;
                            r_tdata    <= w_first_word;
                            r_tlast    <= (w_last_idx == '0);
                            r_tvalid   <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (r_tvalid && m00_axis_tready) begin
                        if (r_tlast) begin
                            r_state       <= ST_FIN;
                            r_tvalid      <= 1'b0;
                            r_tlast       <= 1'b0;
                            r_busy        <= 1'b0;
                            r_done        <= 1'b1;
                            r_frame_count <= r_frame_count + 16'd1;
                        end else begin
                            r_idx   <= w_next_idx;
                            r_tdata <= r_buf[w_next_idx];
                            r_tlast <= (w_next_idx == r_last_idx);
                        end
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign frame_count     = r_frame_count;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tlast  = r_tlast;
    assign m00_axis_tstrb  = '1;

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_frame_source
//  Purpose  : Directed self-checking bench for axis_frame_source.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_frame_source;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  frame_len;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic        tready;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] tb_buf [16];
    logic [15:0] exp_count = 16'd0;

    axis_frame_source #(
        .C_M00_AXIS_TDATA_WIDTH(32),
        .C_FRAME_DEPTH(16),
        .C_ADDR_WIDTH(4)
    ) dut (
        .m00_axis_aclk   (clk),
        .m00_axis_areset (rst),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .frame_len       (frame_len),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .frame_count     (frame_count),
        .m00_axis_tvalid (tvalid),
        .m00_axis_tdata  (tdata),
        .m00_axis_tstrb  (tstrb),
        .m00_axis_tlast  (tlast),
        .m00_axis_tready (tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [3:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tb_buf[addr] = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Issue one frame and follow it beat by beat until done.
    // bp    : apply the tready pattern 0,0,1,0,1,1,0,1 then hold high
    // poke  : pulse start and write buf[0]=DEAD while the frame is in flight
    // same_wr: write buf[0]=same_val in the same cycle as start
    task automatic do_frame(input int len, input int exp_n, input bit bp,
                            input bit poke, input bit same_wr, input logic [31:0] same_val);
        logic [7:0] pat;
        int  beat;
        int  cyc;
        bit  want_done;
        bit  got_done;
        pat       = 8'b1011_0100;  // bit i is tready in cycle i
        beat      = 0;
        cyc       = 0;
        want_done = (exp_n == 0);
        got_done  = 1'b0;
        frame_len = 5'(len);
        start     = 1'b1;
        tready    = 1'b0;
        if (same_wr) begin
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            wr_data = same_val;
            tb_buf[0] = same_val;
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        while (!got_done && cyc < 200) begin
            if (want_done) begin
                exp_count = exp_count + 16'd1;
                chk("done_pulse", done, 1);
                chk("busy_fin", busy, 0);
                chk("tvalid_fin", tvalid, 0);
                chk("frame_count", frame_count, exp_count);
                got_done = 1'b1;
            end else begin
                chk("tvalid_send", tvalid, 1);
                chk("busy_send", busy, 1);
                chk("done_early", done, 0);
                tready = bp ? ((cyc < 8) ? pat[cyc[2:0]] : 1'b1) : 1'b1;
                start  = poke && (cyc == 2);
                wr_en  = poke && (cyc == 2);
                wr_addr = 4'd0;
                wr_data = 32'hDEAD;
                chk(tready ? "tdata_beat" : "tdata_stall", tdata, tb_buf[beat[3:0]]);
                chk(tready ? "tlast_beat" : "tlast_stall", tlast, (beat == exp_n - 1));
                if (tvalid && tready) begin
                    beat++;
                    if (beat == exp_n) want_done = 1'b1;
                end
                @(negedge clk);
                start = 1'b0;
                wr_en = 1'b0;
                cyc++;
            end
        end
        chk("frame_timeout", got_done, 1);
        chk("beat_count", beat, exp_n);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("idle_tvalid", tvalid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 32'd0;
        frame_len = 5'd0;
        start     = 1'b0;
        tready    = 1'b0;
        for (int i = 0; i < 16; i++) tb_buf[i] = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tstrb", tstrb, 4'hF);
        rst = 1'b0;
        @(negedge clk);

        // Preload buf[i] = i+1
        for (int i = 0; i < 16; i++) write_word(4'(i), 32'(i + 1));

        // Basic 16-word frame at full throughput
        do_frame(16, 16, 1'b0, 1'b0, 1'b0, 32'd0);
        // Backpressure on a 4-word frame
        do_frame(4, 4, 1'b1, 1'b0, 1'b0, 32'd0);
        // Boundaries: single beat, empty frame, oversize clamped to depth
        do_frame(1, 1, 1'b0, 1'b0, 1'b0, 32'd0);
        do_frame(0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        do_frame(20, 16, 1'b0, 1'b0, 1'b0, 32'd0);
        // Start and write during SEND are ignored; buf[0] still 1 afterwards
        do_frame(16, 16, 1'b0, 1'b1, 1'b0, 32'd0);
        @(negedge clk);
        chk("no_second_frame", tvalid, 0);
        do_frame(2, 2, 1'b0, 1'b0, 1'b0, 32'd0);
        // Write and start in the same idle cycle: frame carries the new word
        do_frame(2, 2, 1'b0, 1'b0, 1'b1, 32'h0000_0055);
        write_word(4'd0, 32'd1);

        // Reset in the middle of a frame
        frame_len = 5'd16;
        start     = 1'b1;
        tready    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_tdata", tdata, 32'd6);
        rst = 1'b1;
        #1;
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_count", frame_count, 0);
        chk("mid_rst_tlast", tlast, 0);
        @(negedge clk);
        chk("mid_rst_done", done, 0);
        rst       = 1'b0;
        tready    = 1'b0;
        exp_count = 16'd0;
        @(negedge clk);
        do_frame(16, 16, 1'b0, 1'b0, 1'b0, 32'd0);

        // Counter wrap from 0xFFFF to 0
        force dut.r_frame_count = 16'hFFFF;
        #1;
        release dut.r_frame_count;
        exp_count = 16'hFFFF;
        @(negedge clk);
        do_frame(0, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("wrap_zero", frame_count, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
